// File: rtl/bot_regif_pkg.sv
// Shared constants for the BOT 4.x PicoBlaze register interface:
// I/O port map, system register indices and status bit positions.
package bot_regif_pkg;

    localparam int unsigned PA_W = 5;

    localparam logic [PA_W-1:0] PA_MOTCTL      = 5'h00;
    localparam logic [PA_W-1:0] PA_BOTCFG      = 5'h07;
    localparam logic [PA_W-1:0] PA_MAPX        = 5'h08;
    localparam logic [PA_W-1:0] PA_MAPY        = 5'h09;
    localparam logic [PA_W-1:0] PA_MAPVAL      = 5'h0A;
    localparam logic [PA_W-1:0] PA_COMMIT      = 5'h0C;
    localparam logic [PA_W-1:0] PA_HEARTBEAT   = 5'h0E;
    localparam logic [PA_W-1:0] PA_STATUS      = 5'h0F;
    localparam logic [PA_W-1:0] PA_SYSREG_BASE = 5'h10;

    localparam int unsigned SR_LOCX    = 0;
    localparam int unsigned SR_LOCY    = 1;
    localparam int unsigned SR_BOTINFO = 2;
    localparam int unsigned SR_SENSORS = 3;
    localparam int unsigned SR_LMDIST  = 4;
    localparam int unsigned SR_RMDIST  = 5;

    localparam int unsigned ST_IRQ     = 0;
    localparam int unsigned ST_OVERRUN = 1;
    localparam int unsigned ST_ALIVE   = 2;

endpackage

// File: rtl/bot_wdog.sv
// Heartbeat watchdog: reloads on kick, counts down to zero, alive while nonzero.
module bot_wdog #(
    parameter int unsigned WDOG_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic kick,
    output logic alive
);

    localparam int unsigned CNT_W = $clog2(WDOG_CYCLES + 1);

    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             alive_d, alive_q;

    always_comb begin
        cnt_d = cnt_q;
        if (kick) begin
            cnt_d = CNT_W'(WDOG_CYCLES);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
        // alive tracks the next count so it stays aligned with cnt_q
        alive_d = (cnt_d != '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            alive_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            alive_q <= alive_d;
        end
    end

    assign alive = alive_q;

endmodule

// File: rtl/bot_regif_gen.sv
// PicoBlaze I/O register interface: holding registers with atomic commit to
// sys_regs, sticky update interrupt with overrun, map address regs, watchdog.
module bot_regif_gen
    import bot_regif_pkg::*;
#(
    parameter int unsigned NUM_SYS_REGS = 6,
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned WDOG_CYCLES  = 1000000
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           wr_strobe,
    input  logic                           rd_strobe,
    input  logic [7:0]                     port_id,
    input  logic [DATA_W-1:0]              data_in,
    output logic [DATA_W-1:0]              data_out,
    input  logic [DATA_W-1:0]              mot_ctl,
    input  logic [DATA_W-1:0]              bot_config,
    input  logic [1:0]                     map_val,
    output logic [DATA_W-1:0]              map_x,
    output logic [DATA_W-1:0]              map_y,
    output logic [NUM_SYS_REGS*DATA_W-1:0] sys_regs,
    output logic                           upd_irq,
    input  logic                           upd_ack,
    output logic                           bot_alive
);

    localparam int unsigned SYS_W = NUM_SYS_REGS * DATA_W;

    logic [PA_W-1:0]   addr;
    logic              hb_kick;

    logic [DATA_W-1:0] hold_d [NUM_SYS_REGS];
    logic [DATA_W-1:0] hold_q [NUM_SYS_REGS];
    logic [SYS_W-1:0]  sys_regs_d, sys_regs_q;
    logic [DATA_W-1:0] map_x_d, map_x_q;
    logic [DATA_W-1:0] map_y_d, map_y_q;
    logic [DATA_W-1:0] data_out_d, data_out_q;
    logic              commit_d, commit_q;
    logic              upd_irq_d, upd_irq_q;
    logic              overrun_d, overrun_q;

    // rd_strobe is not needed (reads are continuous) and port_id[7:5] is not decoded
    logic unused_inputs;
    assign unused_inputs = ^{rd_strobe, port_id[7:PA_W]};

    assign addr = port_id[PA_W-1:0];

    always_comb begin
        hold_d     = hold_q;
        sys_regs_d = sys_regs_q;
        map_x_d    = map_x_q;
        map_y_d    = map_y_q;
        upd_irq_d  = upd_irq_q;
        overrun_d  = overrun_q;
        data_out_d = '0;
        commit_d   = wr_strobe && (addr == PA_COMMIT);
        hb_kick    = wr_strobe && (addr == PA_HEARTBEAT);

        // Register writes
        if (wr_strobe) begin
            if (addr == PA_MAPX) map_x_d = data_in;
            if (addr == PA_MAPY) map_y_d = data_in;
            if (addr == PA_STATUS) overrun_d = 1'b0;
            for (int unsigned i = 0; i < NUM_SYS_REGS; i++) begin
                if (addr == PA_W'(PA_SYSREG_BASE + i)) hold_d[i] = data_in;
            end
        end

        // Commit load, interrupt set has priority over acknowledge
        if (commit_q) begin
            for (int unsigned i = 0; i < NUM_SYS_REGS; i++) begin
                sys_regs_d[i*DATA_W +: DATA_W] = hold_q[i];
            end
            upd_irq_d = 1'b1;
            if (upd_irq_q && !upd_ack) overrun_d = 1'b1;
        end else if (upd_ack) begin
            upd_irq_d = 1'b0;
        end

        // Read mux, registered into data_out
        case (addr)
            PA_MOTCTL: data_out_d = mot_ctl;
            PA_BOTCFG: data_out_d = bot_config;
            PA_MAPX:   data_out_d = map_x_q;
            PA_MAPY:   data_out_d = map_y_q;
            PA_MAPVAL: data_out_d = DATA_W'(map_val);
            PA_STATUS: begin
                data_out_d[ST_IRQ]     = upd_irq_q;
                data_out_d[ST_OVERRUN] = overrun_q;
                data_out_d[ST_ALIVE]   = bot_alive;
            end
            default: begin
                for (int unsigned i = 0; i < NUM_SYS_REGS; i++) begin
                    if (addr == PA_W'(PA_SYSREG_BASE + i)) data_out_d = hold_q[i];
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_SYS_REGS; i++) begin
                hold_q[i] <= '0;
            end
            sys_regs_q <= '0;
            map_x_q    <= '0;
            map_y_q    <= '0;
            data_out_q <= '0;
            commit_q   <= 1'b0;
            upd_irq_q  <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            hold_q     <= hold_d;
            sys_regs_q <= sys_regs_d;
            map_x_q    <= map_x_d;
            map_y_q    <= map_y_d;
            data_out_q <= data_out_d;
            commit_q   <= commit_d;
            upd_irq_q  <= upd_irq_d;
            overrun_q  <= overrun_d;
        end
    end

    bot_wdog #(
        .WDOG_CYCLES(WDOG_CYCLES)
    ) u_wdog (
        .clk  (clk),
        .reset(reset),
        .kick (hb_kick),
        .alive(bot_alive)
    );

    assign data_out = data_out_q;
    assign map_x    = map_x_q;
    assign map_y    = map_y_q;
    assign sys_regs = sys_regs_q;
    assign upd_irq  = upd_irq_q;

endmodule

// File: tb/tb_bot_regif_gen.sv
// Bench for bot_regif_gen: transaction-level model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_bot_regif_gen;

    localparam int NSR = 6;
    localparam int WD  = 8;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           wr_strobe = 1'b0;
    logic           rd_strobe = 1'b0;
    logic [7:0]     port_id = 8'h00;
    logic [7:0]     data_in = 8'h00;
    logic [7:0]     data_out;
    logic [7:0]     mot_ctl = 8'h00;
    logic [7:0]     bot_config = 8'h00;
    logic [1:0]     map_val = 2'b00;
    logic [7:0]     map_x, map_y;
    logic [NSR*8-1:0] sys_regs;
    logic           upd_irq;
    logic           upd_ack = 1'b0;
    logic           bot_alive;

    int n_cmp = 0;
    int n_bad = 0;
    bit started = 0;

    bot_regif_gen #(.NUM_SYS_REGS(NSR), .DATA_W(8), .WDOG_CYCLES(WD)) dut (
        .clk(clk), .reset(reset), .wr_strobe(wr_strobe), .rd_strobe(rd_strobe),
        .port_id(port_id), .data_in(data_in), .data_out(data_out),
        .mot_ctl(mot_ctl), .bot_config(bot_config), .map_val(map_val),
        .map_x(map_x), .map_y(map_y), .sys_regs(sys_regs),
        .upd_irq(upd_irq), .upd_ack(upd_ack), .bot_alive(bot_alive)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [7:0] m_hold [NSR];
    logic [7:0] m_sys  [NSR];
    logic [7:0] m_mapx = 0, m_mapy = 0, m_dout = 0;
    bit         m_irq = 0, m_ovr = 0, m_load_next = 0;
    int         m_wd = 0;

    function automatic logic [7:0] m_read(input logic [7:0] pid);
        int a;
        a = int'(pid % 32);
        if (a == 0)  return mot_ctl;
        if (a == 7)  return bot_config;
        if (a == 8)  return m_mapx;
        if (a == 9)  return m_mapy;
        if (a == 10) return {6'b0, map_val};
        if (a == 15) return {5'b0, (m_wd > 0), m_ovr, m_irq};
        if (a >= 16 && a - 16 < NSR) return m_hold[a-16];
        return 8'h00;
    endfunction

    function automatic logic [NSR*8-1:0] m_sysvec();
        logic [NSR*8-1:0] v;
        for (int i = 0; i < NSR; i++) v[i*8 +: 8] = m_sys[i];
        return v;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NSR; i++) begin m_hold[i] = 0; m_sys[i] = 0; end
            m_mapx = 0; m_mapy = 0; m_dout = 0; m_irq = 0; m_ovr = 0;
            m_load_next = 0; m_wd = 0;
        end else begin
            int a;
            bit load;
            a = int'(port_id % 32);
            m_dout = m_read(port_id);
            load = m_load_next;
            m_load_next = wr_strobe && a == 12;
            if (load) begin
                for (int i = 0; i < NSR; i++) m_sys[i] = m_hold[i];
                if (m_irq && !upd_ack) m_ovr = 1;
                m_irq = 1;
            end else if (upd_ack) begin
                m_irq = 0;
            end
            if (wr_strobe) begin
                if (a == 8) m_mapx = data_in;
                if (a == 9) m_mapy = data_in;
                if (a == 15) m_ovr = 0;
                if (a >= 16 && a - 16 < NSR) m_hold[a-16] = data_in;
            end
            if (wr_strobe && a == 14) m_wd = WD;
            else if (m_wd > 0) m_wd = m_wd - 1;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle compare against the model
    always @(negedge clk) begin
        if (started && !reset) begin
            chk("model_data_out", 64'(data_out), 64'(m_dout));
            chk("model_sys_regs", 64'(sys_regs), 64'(m_sysvec()));
            chk("model_map_x", 64'(map_x), 64'(m_mapx));
            chk("model_map_y", 64'(map_y), 64'(m_mapy));
            chk("model_upd_irq", 64'(upd_irq), 64'(m_irq));
            chk("model_bot_alive", 64'(bot_alive), 64'(m_wd > 0));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic wr, input logic [7:0] a, input logic [7:0] d, input logic ack);
        wr_strobe = wr; port_id = a; data_in = d; upd_ack = ack;
        @(negedge clk);
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        step(1'b1, a, d, 1'b0);
        step(1'b0, a, 8'h00, 1'b0);
    endtask

    task automatic rd(input logic [7:0] a, output logic [7:0] v);
        step(1'b0, a, 8'h00, 1'b0);
        v = data_out;
    endtask

    function automatic logic [7:0] reg_at(input int i);
        return sys_regs[i*8 +: 8];
    endfunction

    initial begin
        logic [7:0] v;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        started = 1;
        chk("reset_sys_regs", 64'(sys_regs), 64'h0);
        chk("reset_alive", 64'(bot_alive), 64'h0);

        // Map registers and plain reads
        wr(8'h08, 8'h7F);
        wr(8'h09, 8'h40);
        chk("map_x", 64'(map_x), 64'h7F);
        chk("map_y", 64'(map_y), 64'h40);
        map_val = 2'b10;
        rd(8'h0A, v); chk("rd_mapval", 64'(v), 64'h02);
        rd(8'h1F, v); chk("rd_unmapped_1f", 64'(v), 64'h00);
        mot_ctl = 8'hA5;
        rd(8'h00, v); chk("rd_motctl", 64'(v), 64'hA5);
        bot_config = 8'h3C;
        rd(8'hE7, v); chk("rd_botcfg_alias", 64'(v), 64'h3C);

        // Atomic commit
        wr(8'h10, 8'h12);
        wr(8'h11, 8'h34);
        wr(8'h13, 8'h5A);
        chk("hold_no_effect", 64'(sys_regs), 64'h0);
        step(1'b1, 8'h0C, 8'h00, 1'b0);
        chk("commit_strobe_edge", 64'(sys_regs), 64'h0);
        step(1'b0, 8'h0C, 8'h00, 1'b0);
        chk("commit_reg0", 64'(reg_at(0)), 64'h12);
        chk("commit_reg1", 64'(reg_at(1)), 64'h34);
        chk("commit_reg3", 64'(reg_at(3)), 64'h5A);
        chk("commit_irq", 64'(upd_irq), 64'h1);
        rd(8'h11, v); chk("rd_hold1", 64'(v), 64'h34);

        // Overrun
        wr(8'h0C, 8'h00);
        rd(8'h0F, v); chk("status_overrun", 64'(v), 64'h03);
        step(1'b0, 8'h0F, 8'h00, 1'b1);
        chk("ack_clears_irq", 64'(upd_irq), 64'h0);
        rd(8'h0F, v); chk("status_after_ack", 64'(v), 64'h02);
        wr(8'h0F, 8'h55);
        rd(8'h0F, v); chk("status_cleared", 64'(v), 64'h00);

        // Load and ack on same edge, from irq=0 then from irq=1
        step(1'b1, 8'h0C, 8'h00, 1'b0);
        step(1'b0, 8'h0F, 8'h00, 1'b1);
        chk("load_ack_irq0", 64'(upd_irq), 64'h1);
        rd(8'h0F, v); chk("load_ack_status0", 64'(v), 64'h01);
        step(1'b1, 8'h0C, 8'h00, 1'b0);
        step(1'b0, 8'h0F, 8'h00, 1'b1);
        chk("load_ack_irq1", 64'(upd_irq), 64'h1);
        rd(8'h0F, v); chk("load_ack_status1", 64'(v), 64'h01);

        // Watchdog: alive for exactly WD cycles
        step(1'b1, 8'h0E, 8'h00, 1'b0);
        chk("wd_cycle1", 64'(bot_alive), 64'h1);
        for (int k = 1; k < WD; k++) begin
            step(1'b0, 8'h0E, 8'h00, 1'b0);
            chk("wd_alive", 64'(bot_alive), 64'h1);
        end
        step(1'b0, 8'h0E, 8'h00, 1'b0);
        chk("wd_expired", 64'(bot_alive), 64'h0);
        // Heartbeat on the final count: no low cycle
        step(1'b1, 8'h0E, 8'h00, 1'b0);
        for (int k = 1; k < WD; k++) step(1'b0, 8'h0E, 8'h00, 1'b0);
        chk("wd_count1_alive", 64'(bot_alive), 64'h1);
        step(1'b1, 8'h0E, 8'h00, 1'b0);
        chk("wd_reload_no_glitch", 64'(bot_alive), 64'h1);
        rd(8'h0F, v); chk("status_alive", 64'(v), 64'h05);

        // Asynchronous reset in the middle of a commit
        wr(8'h12, 8'h77);
        step(1'b1, 8'h0C, 8'h00, 1'b0);
        #2;
        reset = 1'b1;
        wr_strobe = 1'b0; upd_ack = 1'b0;
        #1;
        chk("async_sys_regs", 64'(sys_regs), 64'h0);
        chk("async_map_x", 64'(map_x), 64'h0);
        chk("async_map_y", 64'(map_y), 64'h0);
        chk("async_irq", 64'(upd_irq), 64'h0);
        chk("async_alive", 64'(bot_alive), 64'h0);
        chk("async_data_out", 64'(data_out), 64'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        step(1'b0, 8'h0F, 8'h00, 1'b0);
        chk("commit_discarded_irq", 64'(upd_irq), 64'h0);
        chk("commit_discarded_sys", 64'(sys_regs), 64'h0);
        rd(8'h0F, v); chk("status_after_reset", 64'(v), 64'h00);
        rd(8'h12, v); chk("hold_after_reset", 64'(v), 64'h00);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
